screen_controller: RTL and testbench
====================================

# screen_controller

Menu/dispense sequencer for the drug dispenser. Debounces the four pushbuttons and runs the user-facing state machine. Produces the one-hot screen-select code and the `dispensing` flag consumed directly by the VGA screen-selection stage. Owns timed dispense cycles triggered by the scheduler or from the manual screen.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before a key level is accepted (10 ms @ 50 MHz).
- `DISPENSE_SECONDS`, 5: `tick_1s` pulses spent in a dispense cycle; ≥1.
- `IDLE_SECONDS`, 30: `tick_1s` pulses without a key press before a sub-screen returns to menu; ≥1.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `key`  in  4: raw pushbuttons, active-low, asynchronous to `clock`.
- `tick_1s`  in  1: one-cycle pulse once per second, synchronous to `clock`.
- `dispense_req`  in  1: one-cycle scheduler request to dispense.
- `inp`  out  4: screen select, one-hot or zero: 0000 menu, 0001 about, 0010 manual, 0100 dispenser, 1000 timeset.
- `dispensing`  out  1: high for the whole dispense cycle.
- `dispense_done`  out  1: one-cycle pulse at end of a dispense cycle.

## Operation
- Every key goes through a 2-FF synchronizer, then a debouncer. The debounced level changes only after the synchronized level has been stable for `DEBOUNCE_CYCLES` consecutive cycles.
- A press event is a one-cycle pulse on the debounced released→pressed edge. Release produces no event.
- FSM states: MENU, ABOUT, MANUAL, DISPENSER, TIMESET, DISPENSE.
- Output `inp` by state:
  - MENU and DISPENSE: 0000.
  - ABOUT: 0001.
  - MANUAL: 0010.
  - DISPENSER: 0100.
  - TIMESET: 1000.
- `dispensing` = 1 only in DISPENSE.
- MENU transitions on press: key[0]→ABOUT, key[1]→MANUAL, key[2]→DISPENSER, key[3]→TIMESET.
- Sub-screen transitions:
  - Pressing the key that selected the screen returns to MENU.
  - In MANUAL, key[3] enters DISPENSE.
  - All other presses are ignored.
- Idle timeout:
  - In sub-screens, an idle counter counts `tick_1s` pulses.
  - On reaching `IDLE_SECONDS` the FSM goes to MENU.
  - Any press event (including ignored ones) clears the counter.
  - The counter clears on every state entry.
- Dispense trigger: `dispense_req` from any non-DISPENSE state enters DISPENSE.
- DISPENSE cycle:
  - The counter clears on entry and counts `tick_1s` pulses.
  - On the `DISPENSE_SECONDS`-th pulse, `dispense_done` pulses and the FSM goes to MENU.
  - Key events are ignored in DISPENSE.
- Pending request: a `dispense_req` arriving during DISPENSE sets a 1-deep `pending` flag; further requests are dropped.
- On exit from DISPENSE with `pending` = 1, the FSM re-enters DISPENSE instead of MENU, clears `pending`, and pulses `dispense_done` for the finished cycle.
- Counter widths: `$clog2(N+1)` for each limit N. Counters saturate and never wrap.

## Timing
- Reset (asynchronous assert): state MENU, `inp` = 0000, `dispensing` = 0, `dispense_done` = 0, `pending` = 0, all counters 0, debounced levels = released.
- All outputs are registered, reflecting state one cycle after the triggering event:
  - Key press: raw edge → state change after 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) + 1 (state) cycles.
  - `dispense_req` → `dispensing` = 1 on the next cycle.
- Simultaneous events:
  - `dispense_req` and a press event in the same cycle: dispense wins and the press is discarded.
  - Several press events in one cycle: priority key[0] > key[3] > key[2] > key[1].
  - Press event and `tick_1s` in the same cycle in a sub-screen: the press wins and the idle counter clears.
- A `tick_1s` coincident with DISPENSE entry is not counted.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no event.
- A held key produces exactly one event.
- Reset mid-dispense: `dispensing` drops immediately, with no `dispense_done`.

## Structure
- Shared package holds:
  - State encoding typedef.
  - The `inp` one-hot constants (SCR_MENU, SCR_ABOUT, SCR_MANUAL, SCR_DISPENSER, SCR_TIMESET), reused by the VGA stage.
- Sub-module `key_debounce` (sync + stable counter + press pulse, parameterised by `DEBOUNCE_CYCLES`), instantiated four times.
- FSM, idle/dispense counters and `pending` live in the top.

## Test plan
- `DEBOUNCE_CYCLES`=4. Reset, then press key[2] clean for 10 cycles → `inp` = 0100 exactly 8 cycles after the raw edge. Press key[2] again → `inp` = 0000.
- key[0] toggling every 2 cycles for 20 cycles, then released → no event, `inp` stays 0000.
- In ABOUT with `IDLE_SECONDS`=3: 3 `tick_1s` pulses with no key → `inp` = 0000. Repeat with a key[3] press between ticks 2 and 3 → still 0001 after 3 ticks.
- MANUAL, press key[3] with `DISPENSE_SECONDS`=2 → `dispensing` = 1 next cycle. After 2 ticks: `dispense_done` one-cycle pulse, `dispensing` = 0, `inp` = 0000.
- During DISPENSE, pulse `dispense_req` twice → after cycle 1, one `dispense_done` pulse, `dispensing` stays 1 for one more full cycle, then a second `dispense_done` pulse and MENU.
- `dispense_req` and a key[0] event in the same cycle → DISPENSE, not ABOUT. Assert `reset` mid-dispense → `dispensing` = 0 asynchronously, no `dispense_done` pulse.

Source files
------------

// File: rtl/screen_controller_pkg.sv
// Shared definitions for the dispenser screen sequencer and the VGA screen-selection stage.
package screen_controller_pkg;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_ABOUT     = 3'd1,
        ST_MANUAL    = 3'd2,
        ST_DISPENSER = 3'd3,
        ST_TIMESET   = 3'd4,
        ST_DISPENSE  = 3'd5
    } state_e;

    localparam logic [3:0] SCR_MENU      = 4'b0000;
    localparam logic [3:0] SCR_ABOUT     = 4'b0001;
    localparam logic [3:0] SCR_MANUAL    = 4'b0010;
    localparam logic [3:0] SCR_DISPENSER = 4'b0100;
    localparam logic [3:0] SCR_TIMESET   = 4'b1000;

    function automatic logic [3:0] screen_code(input state_e st);
        logic [3:0] code;
        case (st)
            ST_ABOUT:     code = SCR_ABOUT;
            ST_MANUAL:    code = SCR_MANUAL;
            ST_DISPENSER: code = SCR_DISPENSER;
            ST_TIMESET:   code = SCR_TIMESET;
            default:      code = SCR_MENU;
        endcase
        return code;
    endfunction

    // Key index that opened a sub-screen; pressing it again goes back to the menu.
    function automatic logic [1:0] home_key(input state_e st);
        logic [1:0] k;
        case (st)
            ST_ABOUT:     k = 2'd0;
            ST_MANUAL:    k = 2'd1;
            ST_DISPENSER: k = 2'd2;
            ST_TIMESET:   k = 2'd3;
            default:      k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/screen_controller_key_debounce.sv
// One pushbutton: 2-FF synchronizer, stable-level debouncer and a registered press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          raw_pressed_s;

    assign raw_pressed_s = ~sync2_q;
    assign press_o       = press_q;

    // Accept the synchronized level once it has differed from the debounced one long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (raw_pressed_s == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q >= CNT_LAST) begin
            level_d = raw_pressed_s;
            cnt_d   = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer, debounce state and released->pressed edge detect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= {CW{1'b0}};
        end else begin
            sync1_q     <= key_n_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/screen_controller.sv
// Menu/dispense sequencer: debounced keys drive the screen FSM; timed dispense cycles with a 1-deep pending request.
module screen_controller
    import screen_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int DISPENSE_SECONDS = 5,
    parameter int IDLE_SECONDS     = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       tick_1s,
    input  logic       dispense_req,
    output logic [3:0] inp,
    output logic       dispensing,
    output logic       dispense_done
);

    localparam int IW = $clog2(IDLE_SECONDS + 1);
    localparam int DW = $clog2(DISPENSE_SECONDS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_SECONDS - 1);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISPENSE_SECONDS - 1);

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;
    logic [DW-1:0] disp_q;
    logic [DW-1:0] disp_d;
    logic          pending_q;
    logic          pending_d;
    logic          done_d;
    logic          reenter_s;
    logic [3:0]    press_s;
    logic          press_any_s;
    logic [1:0]    sel_s;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clock   (clock),
            .reset   (reset),
            .key_n_i (key[g]),
            .press_o (press_s[g])
        );
    end

    // Pick a single key when several press events coincide: 0 > 3 > 2 > 1.
    always_comb begin
        press_any_s = |press_s;
        if (press_s[0]) begin
            sel_s = 2'd0;
        end else if (press_s[3]) begin
            sel_s = 2'd3;
        end else if (press_s[2]) begin
            sel_s = 2'd2;
        end else if (press_s[1]) begin
            sel_s = 2'd1;
        end else begin
            sel_s = 2'd0;
        end
    end

    // Next-state, counters and pending flag.
    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        reenter_s = 1'b0;
        case (state_q)
            ST_MENU: begin
                if (dispense_req) begin
                    state_d = ST_DISPENSE;
                end else if (press_any_s) begin
                    case (sel_s)
                        2'd0:    state_d = ST_ABOUT;
                        2'd1:    state_d = ST_MANUAL;
                        2'd2:    state_d = ST_DISPENSER;
                        default: state_d = ST_TIMESET;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_ABOUT, ST_MANUAL, ST_DISPENSER, ST_TIMESET: begin
                if (dispense_req) begin
                    state_d = ST_DISPENSE;
                end else if (press_any_s) begin
                    idle_d = {IW{1'b0}};
                    if (sel_s == home_key(state_q)) begin
                        state_d = ST_MENU;
                    end else if ((state_q == ST_MANUAL) && (sel_s == 2'd3)) begin
                        state_d = ST_DISPENSE;
                    end else begin
                        state_d = state_q;
                    end
                end else if (tick_1s) begin
                    if (idle_q >= IDLE_LAST) begin
                        state_d = ST_MENU;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end else begin
                    idle_d = idle_q;
                end
            end
            ST_DISPENSE: begin
                // A request already pending makes further ones no-ops.
                if (dispense_req) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (tick_1s) begin
                    if (disp_q >= DISP_LAST) begin
                        done_d = 1'b1;
                        if (pending_q || dispense_req) begin
                            reenter_s = 1'b1;
                            pending_d = 1'b0;
                        end else begin
                            state_d = ST_MENU;
                        end
                    end else begin
                        disp_d = disp_q + DW'(1);
                    end
                end else begin
                    disp_d = disp_q;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
        if ((state_d != state_q) || reenter_s) begin
            idle_d = {IW{1'b0}};
            disp_d = {DW{1'b0}};
        end else begin
            idle_d = idle_d;
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_MENU;
            idle_q        <= {IW{1'b0}};
            disp_q        <= {DW{1'b0}};
            pending_q     <= 1'b0;
            inp           <= SCR_MENU;
            dispensing    <= 1'b0;
            dispense_done <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_q        <= idle_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            inp           <= screen_code(state_d);
            dispensing    <= (state_d == ST_DISPENSE);
            dispense_done <= done_d;
        end
    end

endmodule

// File: tb/tb_screen_controller.sv
// Directed bench for screen_controller with short debounce, idle and dispense limits.
module tb_screen_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key = 4'b1111;
    logic       tick_1s = 1'b0;
    logic       dispense_req = 1'b0;
    logic [3:0] inp;
    logic       dispensing;
    logic       dispense_done;
    int         checks = 0;
    int         failures = 0;

    screen_controller #(
        .DEBOUNCE_CYCLES  (4),
        .DISPENSE_SECONDS (2),
        .IDLE_SECONDS     (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key           (key),
        .tick_1s       (tick_1s),
        .dispense_req  (dispense_req),
        .inp           (inp),
        .dispensing    (dispensing),
        .dispense_done (dispense_done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press_key(input int k);
        key[k] = 1'b0;
        repeat (10) step();
        key[k] = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL reset_inp got=%b exp=%b", inp, 4'b0000); end
        checks++; if (dispensing !== 1'b0) begin failures++; $display("FAIL reset_dispensing got=%b exp=0", dispensing); end
        checks++; if (dispense_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dispense_done); end
        reset = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_key_latency();
        key[2] = 1'b0;
        repeat (7) step();
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL lat7_inp got=%b exp=%b", inp, 4'b0000); end
        step();
        checks++; if (inp !== 4'b0100) begin failures++; $display("FAIL lat8_inp got=%b exp=%b", inp, 4'b0100); end
        repeat (2) step();
        key[2] = 1'b1;
        repeat (8) step();
        checks++; if (inp !== 4'b0100) begin failures++; $display("FAIL held_once_inp got=%b exp=%b", inp, 4'b0100); end
        press_key(2);
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL key2_back_inp got=%b exp=%b", inp, 4'b0000); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            key[0] = ~key[0];
            repeat (2) step();
        end
        repeat (10) step();
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL bounce_inp got=%b exp=%b", inp, 4'b0000); end
    endtask

    task automatic test_idle();
        press_key(0);
        checks++; if (inp !== 4'b0001) begin failures++; $display("FAIL about_inp got=%b exp=%b", inp, 4'b0001); end
        repeat (2) begin tick_1s = 1'b1; step(); tick_1s = 1'b0; step(); end
        checks++; if (inp !== 4'b0001) begin failures++; $display("FAIL idle2_inp got=%b exp=%b", inp, 4'b0001); end
        tick_1s = 1'b1; step(); tick_1s = 1'b0; step();
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL idle3_inp got=%b exp=%b", inp, 4'b0000); end
        press_key(0);
        repeat (2) begin tick_1s = 1'b1; step(); tick_1s = 1'b0; step(); end
        press_key(3);
        tick_1s = 1'b1; step(); tick_1s = 1'b0; step();
        checks++; if (inp !== 4'b0001) begin failures++; $display("FAIL idle_clr_inp got=%b exp=%b", inp, 4'b0001); end
        repeat (2) begin tick_1s = 1'b1; step(); tick_1s = 1'b0; step(); end
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL idle_clr_to_menu got=%b exp=%b", inp, 4'b0000); end
    endtask

    task automatic test_manual_dispense();
        press_key(1);
        checks++; if (inp !== 4'b0010) begin failures++; $display("FAIL manual_inp got=%b exp=%b", inp, 4'b0010); end
        key[3] = 1'b0;
        repeat (7) step();
        checks++; if (dispensing !== 1'b0) begin failures++; $display("FAIL man_pre_disp got=%b exp=0", dispensing); end
        step();
        checks++; if (dispensing !== 1'b1) begin failures++; $display("FAIL man_disp got=%b exp=1", dispensing); end
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL man_disp_inp got=%b exp=%b", inp, 4'b0000); end
        repeat (2) step();
        key[3] = 1'b1;
        repeat (8) step();
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        checks++; if (dispense_done !== 1'b0 || dispensing !== 1'b1) begin failures++; $display("FAIL man_tick1 done=%b disp=%b exp done=0 disp=1", dispense_done, dispensing); end
        step();
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        checks++; if (dispense_done !== 1'b1) begin failures++; $display("FAIL man_done got=%b exp=1", dispense_done); end
        checks++; if (dispensing !== 1'b0 || inp !== 4'b0000) begin failures++; $display("FAIL man_end disp=%b inp=%b exp disp=0 inp=0000", dispensing, inp); end
        step();
        checks++; if (dispense_done !== 1'b0) begin failures++; $display("FAIL man_done_width got=%b exp=0", dispense_done); end
    endtask

    task automatic test_back_to_back();
        dispense_req = 1'b1; step(); dispense_req = 1'b0;
        checks++; if (dispensing !== 1'b1) begin failures++; $display("FAIL req_disp got=%b exp=1", dispensing); end
        step();
        repeat (2) begin dispense_req = 1'b1; step(); dispense_req = 1'b0; step(); end
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        checks++; if (dispense_done !== 1'b0) begin failures++; $display("FAIL b2b_tick1 got=%b exp=0", dispense_done); end
        step();
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        checks++; if (dispense_done !== 1'b1 || dispensing !== 1'b1) begin failures++; $display("FAIL b2b_first_done done=%b disp=%b exp done=1 disp=1", dispense_done, dispensing); end
        step();
        checks++; if (dispense_done !== 1'b0 || dispensing !== 1'b1) begin failures++; $display("FAIL b2b_second_cycle done=%b disp=%b exp done=0 disp=1", dispense_done, dispensing); end
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        checks++; if (dispense_done !== 1'b0 || dispensing !== 1'b1) begin failures++; $display("FAIL b2b_tick3 done=%b disp=%b exp done=0 disp=1", dispense_done, dispensing); end
        step();
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        checks++; if (dispense_done !== 1'b1 || dispensing !== 1'b0) begin failures++; $display("FAIL b2b_second_done done=%b disp=%b exp done=1 disp=0", dispense_done, dispensing); end
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL b2b_menu got=%b exp=%b", inp, 4'b0000); end
        step();
        checks++; if (dispense_done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%b exp=0", dispense_done); end
    endtask

    task automatic test_collision_and_reset();
        int seen;
        key[0] = 1'b0;
        repeat (7) step();
        dispense_req = 1'b1; step(); dispense_req = 1'b0;
        checks++; if (dispensing !== 1'b1) begin failures++; $display("FAIL coll_disp got=%b exp=1", dispensing); end
        checks++; if (inp !== 4'b0000) begin failures++; $display("FAIL coll_inp got=%b exp=%b", inp, 4'b0000); end
        repeat (2) step();
        key[0] = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (dispensing !== 1'b0) begin failures++; $display("FAIL rst_async_disp got=%b exp=0", dispensing); end
        seen = 0;
        repeat (3) begin
            step();
            if (dispense_done !== 1'b0) seen = 1;
        end
        reset = 1'b1;
        repeat (3) step();
        checks++; if (seen != 0 || dispense_done !== 1'b0) begin failures++; $display("FAIL rst_no_done seen=%0d done=%b exp 0", seen, dispense_done); end
        checks++; if (inp !== 4'b0000 || dispensing !== 1'b0) begin failures++; $display("FAIL rst_after inp=%b disp=%b exp 0000/0", inp, dispensing); end
    endtask

    initial begin
        test_reset();
        test_key_latency();
        test_bounce();
        test_idle();
        test_manual_dispense();
        test_back_to_back();
        test_collision_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
